// File: rtl/idct4_pipe.sv
// Three-stage pipelined 4-point HEVC inverse DCT (kernel 64/83/36) with
// rounding shift, signed saturation and a single global valid/ready stall.
module idct4_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  s0,
  input  logic signed [IN_W-1:0]  s1,
  input  logic signed [IN_W-1:0]  s2,
  input  logic signed [IN_W-1:0]  s3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3,
  output logic [3:0]              out_sat
);

  localparam int IW = IN_W + 10;
  typedef logic signed [IW-1:0] iw_t;

  localparam iw_t C64  = iw_t'(64);
  localparam iw_t C83  = iw_t'(83);
  localparam iw_t C36  = iw_t'(36);
  localparam iw_t RND  = iw_t'(64'sd1 <<< (SHIFT - 1));
  localparam iw_t OMAX = iw_t'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam iw_t OMIN = iw_t'(-(64'sd1 <<< (OUT_W - 1)));

  logic adv;
  logic v1, v2;
  iw_t  m64a, m64b, m83_1, m36_1, m83_3, m36_3;
  iw_t  e0, e1, o0, o1;
  iw_t  p0, p1, p2, p3;

  // Returns {clipped, value} for one lane after rounding shift.
  function automatic logic [OUT_W:0] sat_lane(input iw_t v);
    iw_t r;
    r = (v + RND) >>> SHIFT;
    if (r > OMAX)
      sat_lane = {1'b1, OUT_W'(OMAX)};
    else if (r < OMIN)
      sat_lane = {1'b1, OUT_W'(OMIN)};
    else
      sat_lane = {1'b0, OUT_W'(r)};
  endfunction

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // Data registers only load behind a valid beat; bubbles leave them stale.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      m64a  <= iw_t'(s0) * C64;
      m64b  <= iw_t'(s2) * C64;
      m83_1 <= iw_t'(s1) * C83;
      m36_1 <= iw_t'(s1) * C36;
      m83_3 <= iw_t'(s3) * C83;
      m36_3 <= iw_t'(s3) * C36;
    end
  end

  always_comb begin
    e0 = m64a + m64b;
    e1 = m64a - m64b;
    o0 = m83_1 + m36_3;
    o1 = m36_1 - m83_3;
  end

  always_ff @(posedge clk) begin
    if (adv && v1) begin
      p0 <= e0 + o0;
      p1 <= e1 + o1;
      p2 <= e1 - o1;
      p3 <= e0 - o0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y0      <= '0;
      y1      <= '0;
      y2      <= '0;
      y3      <= '0;
      out_sat <= '0;
    end else if (adv && v2) begin
      {out_sat[0], y0} <= sat_lane(p0);
      {out_sat[1], y1} <= sat_lane(p1);
      {out_sat[2], y2} <= sat_lane(p2);
      {out_sat[3], y3} <= sat_lane(p3);
    end
  end

endmodule

// File: tb/tb_idct4_pipe.sv
// Self-checking bench for idct4_pipe: directed table vectors, randomized
// stall traffic against a plain-arithmetic reference, full-rate and reset-flush runs.
module tb_idct4_pipe;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] s0, s1, s2, s3;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] y0, y1, y2, y3;
  logic [3:0]         out_sat;

  typedef struct {
    int         s [4];
    int         y [4];
    logic [3:0] sat;
  } vec_t;

  typedef struct {
    int         y [4];
    logic [3:0] sat;
  } exp_t;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q [$];
  int   consumed = 0;
  logic prev_stall = 1'b0;
  logic signed [15:0] prev_y [4];
  logic [3:0]         prev_sat;
  vec_t vecs [5];

  idct4_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(7)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: direct matrix form of the 4-point inverse transform.
  function automatic exp_t refModel(input int a, input int b, input int c, input int d);
    exp_t   e;
    longint pre [4];
    longint r;
    pre[0] = 64 * longint'(a) + 83 * longint'(b) + 64 * longint'(c) + 36 * longint'(d);
    pre[1] = 64 * longint'(a) + 36 * longint'(b) - 64 * longint'(c) - 83 * longint'(d);
    pre[2] = 64 * longint'(a) - 36 * longint'(b) - 64 * longint'(c) + 83 * longint'(d);
    pre[3] = 64 * longint'(a) - 83 * longint'(b) + 64 * longint'(c) - 36 * longint'(d);
    e.sat = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      r = (pre[k] + 64) >>> 7;
      if (r > 32767) begin r = 32767; e.sat[k] = 1'b1; end
      if (r < -32768) begin r = -32768; e.sat[k] = 1'b1; end
      e.y[k] = int'(r);
    end
    return e;
  endfunction

  // Scoreboard: accepted beats queue up, consumed beats must match in order.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      checkVal("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        checkVal("stall_valid", longint'(out_valid), 1);
        checkVal("stall_y0", y0, prev_y[0]);
        checkVal("stall_y1", y1, prev_y[1]);
        checkVal("stall_y2", y2, prev_y[2]);
        checkVal("stall_y3", y3, prev_y[3]);
        checkVal("stall_sat", longint'(out_sat), longint'(prev_sat));
      end
      if (out_valid && out_ready) begin
        consumed++;
        checkVal("pending_beats", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkVal("model_y0", y0, e.y[0]);
          checkVal("model_y1", y1, e.y[1]);
          checkVal("model_y2", y2, e.y[2]);
          checkVal("model_y3", y3, e.y[3]);
          checkVal("model_sat", longint'(out_sat), longint'(e.sat));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(refModel(int'(s0), int'(s1), int'(s2), int'(s3)));
      prev_stall = out_valid && !out_ready;
      prev_y[0] = y0; prev_y[1] = y1; prev_y[2] = y2; prev_y[3] = y3;
      prev_sat = out_sat;
    end
  end

  task automatic setData(input int a, input int b, input int c, input int d);
    s0 = 16'(a); s1 = 16'(b); s2 = 16'(c); s3 = 16'(d);
  endtask

  task automatic setRandom();
    setData(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic applyStimulus(input vec_t v);
    logic acc;
    acc = 1'b0;
    setData(v.s[0], v.s[1], v.s[2], v.s[3]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    checkVal("accepted", longint'(acc), 1);
  endtask

  // Wait for the output beat, check latency and values against the table.
  task automatic checkOutput(input vec_t v, input string tag);
    int   lat;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin seen = 1'b1; break; end
    end
    checkVal({tag, "_seen"}, longint'(seen), 1);
    if (seen) begin
      checkVal({tag, "_latency"}, lat, 3);
      checkVal({tag, "_y0"}, y0, v.y[0]);
      checkVal({tag, "_y1"}, y1, v.y[1]);
      checkVal({tag, "_y2"}, y2, v.y[2]);
      checkVal({tag, "_y3"}, y3, v.y[3]);
      checkVal({tag, "_sat"}, longint'(out_sat), longint'(v.sat));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int   sent;
    int   cons0;
    logic acc;

    vecs[0] = '{s: '{1, 0, 0, 0}, y: '{1, 1, 1, 1}, sat: 4'b0000};
    vecs[1] = '{s: '{0, 1, 0, 0}, y: '{1, 0, 0, -1}, sat: 4'b0000};
    vecs[2] = '{s: '{32767, 32767, 32767, 32767}, y: '{32767, -12032, 12032, 2304}, sat: 4'b0001};
    vecs[3] = '{s: '{-32768, -32768, -32768, -32768}, y: '{-32768, 12032, -12032, -2304}, sat: 4'b0001};
    vecs[4] = '{s: '{-1, 0, 0, 0}, y: '{0, 0, 0, 0}, sat: 4'b0000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    setData(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_out_valid", longint'(out_valid), 0);
    checkVal("rst_y0", y0, 0);
    checkVal("rst_y3", y3, 0);
    checkVal("rst_sat", longint'(out_sat), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkVal("post_rst_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Randomized beats with random backpressure.
    cons0 = consumed;
    sent = 0;
    setRandom();
    in_valid = 1'b1;
    out_ready = 1'(($urandom_range(0, 1)));
    for (int c = 0; c < 300 && (sent < 8 || exp_q.size() > 0); c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 8) setRandom();
        else in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkVal("random_sent", sent, 8);
    checkVal("random_drained", exp_q.size(), 0);
    checkVal("random_consumed", consumed - cons0, 8);

    // Full-rate stream: out_valid must be high exactly for cycles 3..18.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) begin
        setRandom();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checkVal($sformatf("stream_valid_c%0d", i), longint'(out_valid), longint'(i >= 3 && i <= 18));
      @(posedge clk); #1;
    end
    checkVal("stream_drained", exp_q.size(), 0);

    // Reset with three beats in flight, then nothing may emerge.
    for (int b = 0; b < 3; b++) begin
      setRandom();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkVal("flight_out_valid", longint'(out_valid), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    cons0 = consumed;
    @(negedge clk);
    checkVal("flush_out_valid", longint'(out_valid), 0);
    checkVal("flush_y0", y0, 0);
    checkVal("flush_y1", y1, 0);
    checkVal("flush_y2", y2, 0);
    checkVal("flush_y3", y3, 0);
    checkVal("flush_sat", longint'(out_sat), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkVal("flush_no_stale", longint'(out_valid), 0);
    end
    checkVal("flush_consumed", consumed - cons0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
